// File: rtl/ppwm_pkg.sv
// ppwm_pkg: shared types and default widths for the PPWM channel blocks.
package ppwm_pkg;

    typedef enum logic {StOff, StRun} pwm_out_state_e;

    localparam int PPWM_COUNTER_WIDTH  = 8;
    localparam int PPWM_PRESCALE_WIDTH = 4;
    localparam int PPWM_DEADTIME_WIDTH = 4;

endpackage

// File: rtl/ppwm_deadtime.sv
// ppwm_deadtime: complementary PWM pair with a both-low gap of deadtime_i cycles on each edge of r_i.
// Only built when PPWM_DEADTIME_EN is defined.
`ifdef PPWM_DEADTIME_EN
module ppwm_deadtime #(
    parameter int DEADTIME_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run_i,
    input  logic                      r_i,
    input  logic [DEADTIME_WIDTH-1:0] deadtime_i,
    output logic                      pwm_o,
    output logic                      pwm_n_o
);

    logic                      r_prev_q;
    logic [DEADTIME_WIDTH-1:0] dt_q, dt_d;
    logic                      pwm_q, pwm_n_q;
    logic                      change, block;

    // The edge cycle itself is the first gap cycle, so the counter holds the remaining deadtime-1.
    assign change = r_i != r_prev_q;
    assign block  = change ? (deadtime_i != '0) : (dt_q != '0);

    always_comb begin
        dt_d = '0;
        if (change)
            dt_d = (deadtime_i != '0) ? deadtime_i - 1'b1 : '0;
        else if (dt_q != '0)
            dt_d = dt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_q <= 1'b0;
            dt_q     <= '0;
            pwm_q    <= 1'b0;
            pwm_n_q  <= 1'b0;
        end else begin
            r_prev_q <= r_i;
            dt_q     <= dt_d;
            pwm_q    <= run_i && r_i && !block;
            pwm_n_q  <= run_i && !r_i && !block;
        end
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;

endmodule
`endif

// File: rtl/pwm_out.sv
// pwm_out: period counter, start pulse and shadowed duty compare for one PPWM channel.
// Define PPWM_DEADTIME_EN to drive pwm_n_o as a complementary output with dead time.
module pwm_out
    import ppwm_pkg::*;
#(
    parameter int COUNTER_WIDTH  = PPWM_COUNTER_WIDTH,
    parameter int PRESCALE_WIDTH = PPWM_PRESCALE_WIDTH,
    parameter int DEADTIME_WIDTH = PPWM_DEADTIME_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [COUNTER_WIDTH-1:0]  period_i,
    input  logic [COUNTER_WIDTH-1:0]  pwm_value_i,
    input  logic [DEADTIME_WIDTH-1:0] deadtime_i,
    output logic                      start_o,
    output logic [COUNTER_WIDTH-1:0]  global_counter_o,
    output logic                      pwm_o,
    output logic                      pwm_n_o
);

    pwm_out_state_e            state_q, state_d;
    logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d, period_q, period_d, duty_q, duty_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d, prescale_q, prescale_d;
    logic                      start_q, start_d;
    logic                      tick, wrap, load, run, r;

    assign tick = presc_q == prescale_q;
    assign wrap = tick && (cnt_q == period_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        load    = 1'b0;
        if (!enable_i) begin
            state_d = StOff;
            cnt_d   = '0;
            presc_d = '0;
        end else if (state_q == StOff) begin
            state_d = StRun;
            cnt_d   = '0;
            presc_d = '0;
            load    = 1'b1;
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = wrap ? '0 : cnt_q + 1'b1;
            load    = wrap;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        start_d    = load;
        period_d   = load ? period_i    : period_q;
        prescale_d = load ? prescale_i  : prescale_q;
        duty_d     = load ? pwm_value_i : duty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            presc_q    <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            duty_q     <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
            start_q    <= start_d;
        end
    end

    assign run              = state_q == StRun;
    assign r                = run && (cnt_q < duty_q);
    assign start_o          = start_q;
    assign global_counter_o = cnt_q;

`ifdef PPWM_DEADTIME_EN
    ppwm_deadtime #(
        .DEADTIME_WIDTH(DEADTIME_WIDTH)
    ) u_deadtime (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run),
        .r_i       (r),
        .deadtime_i(deadtime_i),
        .pwm_o     (pwm_o),
        .pwm_n_o   (pwm_n_o)
    );
`else
    logic pwm_q;
    logic unused_deadtime;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_q <= 1'b0;
        else
            pwm_q <= r;
    end

    assign pwm_o           = pwm_q;
    assign pwm_n_o         = 1'b0;
    assign unused_deadtime = ^deadtime_i;
`endif

endmodule

// File: tb/tb_pwm_out.sv
// tb_pwm_out: scoreboard bench for pwm_out; expectations come from closed-form period arithmetic.
// Define PPWM_DEADTIME_EN to also check the complementary output and its dead-time gaps.
module tb_pwm_out;

    localparam int DT = 2;

    typedef struct {
        logic [7:0] cnt;
        logic       start;
        logic       pwm;
        logic       pwm_n;
    } exp_t;

    typedef struct {
        int s;
        int p;
        int v0;
        int v1;
        int chg;
        int n;
    } scn_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_i;
    logic [3:0] prescale_i;
    logic [7:0] period_i;
    logic [7:0] pwm_value_i;
    logic [3:0] deadtime_i;
    logic       start_o;
    logic [7:0] global_counter_o;
    logic       pwm_o;
    logic       pwm_n_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    pwm_out dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .prescale_i      (prescale_i),
        .period_i        (period_i),
        .pwm_value_i     (pwm_value_i),
        .deadtime_i      (deadtime_i),
        .start_o         (start_o),
        .global_counter_o(global_counter_o),
        .pwm_o           (pwm_o),
        .pwm_n_o         (pwm_n_o)
    );

    always #5 clk = ~clk;

    // Raw compare at run cycle j (0 = first cycle showing counter 0); duty v1 applies after the first wrap.
    function automatic bit ref_r(int j, int s, int p, int v0, int v1, int chg);
        int cnt, duty;
        if (j < 0) return 1'b0;
        cnt  = (j / (s + 1)) % (p + 1);
        duty = (chg >= 0 && j / ((s + 1) * (p + 1)) >= 1) ? v1 : v0;
        return cnt < duty;
    endfunction

    function automatic exp_t ref_at(int k, scn_t c);
        exp_t e;
        e.cnt   = 8'((k / (c.s + 1)) % (c.p + 1));
        e.start = (k % ((c.s + 1) * (c.p + 1))) == 0;
`ifdef PPWM_DEADTIME_EN
        e.pwm   = 1'b1;
        e.pwm_n = k >= 1;
        for (int i = 0; i <= DT; i++) begin
            if (ref_r(k - 1 - i, c.s, c.p, c.v0, c.v1, c.chg)) e.pwm_n = 1'b0;
            else e.pwm = 1'b0;
        end
`else
        e.pwm   = ref_r(k - 1, c.s, c.p, c.v0, c.v1, c.chg);
        e.pwm_n = 1'b0;
`endif
        return e;
    endfunction

    task automatic test_reset();
        rst_n       = 1'b0;
        enable_i    = 1'b1;
        prescale_i  = 4'd0;
        period_i    = 8'd9;
        pwm_value_i = 8'd3;
        deadtime_i  = 4'(DT);
        repeat (3) @(negedge clk);
        checks++;
        if ({start_o, global_counter_o, pwm_o, pwm_n_o} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b cnt=%0d pwm=%b pwm_n=%b want all 0",
                     start_o, global_counter_o, pwm_o, pwm_n_o);
        end
        enable_i = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_o, global_counter_o, pwm_o, pwm_n_o} !== 11'd0) begin
            failures++;
            $display("FAIL idle_after_reset got start=%b cnt=%0d pwm=%b pwm_n=%b want all 0",
                     start_o, global_counter_o, pwm_o, pwm_n_o);
        end
    endtask

    task automatic test_patterns();
        scn_t tbl[$];
        exp_t e;
        tbl.push_back('{s: 0, p: 9, v0: 3,   v1: 3, chg: -1, n: 30});
        tbl.push_back('{s: 3, p: 4, v0: 2,   v1: 2, chg: -1, n: 45});
        tbl.push_back('{s: 0, p: 9, v0: 3,   v1: 7, chg: 4,  n: 25});
        tbl.push_back('{s: 0, p: 9, v0: 0,   v1: 0, chg: -1, n: 20});
        tbl.push_back('{s: 0, p: 9, v0: 255, v1: 255, chg: -1, n: 20});
        tbl.push_back('{s: 1, p: 0, v0: 1,   v1: 1, chg: -1, n: 10});
        tbl.push_back('{s: 0, p: 9, v0: 5,   v1: 5, chg: -1, n: 30});
        foreach (tbl[t]) begin
            prescale_i  = 4'(tbl[t].s);
            period_i    = 8'(tbl[t].p);
            pwm_value_i = 8'(tbl[t].v0);
            enable_i    = 1'b1;
            for (int k = 0; k < tbl[t].n; k++) sb.push_back(ref_at(k, tbl[t]));
            for (int k = 0; k < tbl[t].n; k++) begin
                @(posedge clk);
                #1;
                if (k == tbl[t].chg) pwm_value_i = 8'(tbl[t].v1);
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (global_counter_o !== e.cnt || start_o !== e.start || pwm_o !== e.pwm || pwm_n_o !== e.pwm_n) begin
                    failures++;
                    $display("FAIL pattern%0d_cycle%0d got cnt=%0d start=%b pwm=%b pwm_n=%b want cnt=%0d start=%b pwm=%b pwm_n=%b",
                             t, k, global_counter_o, start_o, pwm_o, pwm_n_o, e.cnt, e.start, e.pwm, e.pwm_n);
                end
            end
            enable_i = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_stop_restart();
        scn_t c;
        exp_t e;
        c = '{s: 0, p: 9, v0: 3, v1: 3, chg: -1, n: 14};
        prescale_i  = 4'd0;
        period_i    = 8'd9;
        pwm_value_i = 8'd3;
        for (int pass = 0; pass < 2; pass++) begin
            enable_i = 1'b1;
            for (int k = 0; k < c.n; k++) sb.push_back(ref_at(k, c));
            for (int k = 0; k < c.n; k++) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (global_counter_o !== e.cnt || start_o !== e.start || pwm_o !== e.pwm || pwm_n_o !== e.pwm_n) begin
                    failures++;
                    $display("FAIL restart%0d_cycle%0d got cnt=%0d start=%b pwm=%b pwm_n=%b want cnt=%0d start=%b pwm=%b pwm_n=%b",
                             pass, k, global_counter_o, start_o, pwm_o, pwm_n_o, e.cnt, e.start, e.pwm, e.pwm_n);
                end
            end
            enable_i = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if ({start_o, global_counter_o, pwm_o, pwm_n_o} !== 11'd0) begin
                failures++;
                $display("FAIL stopped%0d got start=%b cnt=%0d pwm=%b pwm_n=%b want all 0",
                         pass, start_o, global_counter_o, pwm_o, pwm_n_o);
            end
            repeat (4) @(negedge clk);
            c.n = 12;
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stop_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
